// File: rtl/video_pattern_gen_pkg.sv
`default_nettype none
// ==== vid_pkg : shared pattern encoding, bar colour table, frame-size helpers (rev 1.0) ====
package vid_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  // {r,g,b} on/off per bar; bar 0 (white) sits in the low bits.
  localparam logic [23:0] BAR_LUT = {
    3'b000,  // black
    3'b001,  // blue
    3'b100,  // red
    3'b101,  // magenta
    3'b010,  // green
    3'b011,  // cyan
    3'b110,  // yellow
    3'b111   // white
  };

  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    return BAR_LUT[3*int'(idx) +: 3];
  endfunction

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_pattern_gen_if.sv
`default_nettype none
// ==== video_pattern_gen_if : control inputs and RGB/dv/hs/vs stream of the generator (rev 1.0) ====
interface video_pattern_gen_if #(
  parameter int COLORDEPTH = 8
);
  logic                      en_i;
  logic [1:0]                pattern_sel_i;
  logic [3*COLORDEPTH-1:0]   solid_rgb_i;
  logic [COLORDEPTH-1:0]     red_o;
  logic [COLORDEPTH-1:0]     green_o;
  logic [COLORDEPTH-1:0]     blue_o;
  logic                      dv_o;
  logic                      hs_o;
  logic                      vs_o;
  logic                      frame_o;

  modport master (
    input  en_i, pattern_sel_i, solid_rgb_i,
    output red_o, green_o, blue_o, dv_o, hs_o, vs_o, frame_o
  );

  modport slave (
    output en_i, pattern_sel_i, solid_rgb_i,
    input  red_o, green_o, blue_o, dv_o, hs_o, vs_o, frame_o
  );
endinterface
`default_nettype wire

// File: rtl/video_pattern_gen_timing.sv
`default_nettype none
// ==== vid_timing : IDLE/RUN control, h/v counters, bar index and sync decode (rev 1.0) ====
module vid_timing
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic [2:0]    bar_idx,
  output logic          run,
  output logic          dv,
  output logic          hs,
  output logic          vs,
  output logic          frame
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = $clog2(BAR_W + 1);

  logic [0:0]    state;
  logic          stop_req;
  logic [BW-1:0] bar_pix;
  logic          h_last;
  logic          v_last;

  assign h_last = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last = (v_cnt == VW'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      stop_req <= 1'b0;
      h_cnt    <= '0;
      v_cnt    <= '0;
      bar_pix  <= '0;
      bar_idx  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          h_cnt    <= '0;
          v_cnt    <= '0;
          bar_pix  <= '0;
          bar_idx  <= '0;
          stop_req <= 1'b0;
          if (en) state <= ST_RUN;
        end
        default: begin
          // A disable request is remembered so the frame always runs to its end.
          stop_req <= stop_req | ~en;
          if (h_last) begin
            h_cnt   <= '0;
            bar_pix <= '0;
            bar_idx <= '0;
            if (v_last) begin
              v_cnt <= '0;
              if (stop_req || !en) begin
                state    <= ST_IDLE;
                stop_req <= 1'b0;
              end
            end else begin
              v_cnt <= v_cnt + VW'(1);
            end
          end else begin
            h_cnt <= h_cnt + HW'(1);
            if (bar_pix == BW'(BAR_W - 1)) begin
              bar_pix <= '0;
              bar_idx <= bar_idx + 3'd1;
            end else begin
              bar_pix <= bar_pix + BW'(1);
            end
          end
        end
      endcase
    end
  end

  assign run   = (state == ST_RUN);
  assign dv    = run && (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
  assign hs    = run && (int'(h_cnt) >= H_ACTIVE + H_FP)
                     && (int'(h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
  assign vs    = run && (int'(v_cnt) >= V_ACTIVE + V_FP)
                     && (int'(v_cnt) <  V_ACTIVE + V_FP + V_SYNC);
  assign frame = run && (h_cnt == '0) && (v_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/video_pattern_gen.sv
`default_nettype none
// ==== video_pattern_gen : frame-timed RGB test-pattern source (rev 1.0) ====
module video_pattern_gen
  import vid_pkg::*;
#(
  parameter int COLORDEPTH = 8,
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 110,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 220,
  parameter int V_ACTIVE   = 720,
  parameter int V_FP       = 5,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 20,
  parameter int CHECK_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rst,
  video_pattern_gen_if.master bus
);

  localparam int HW = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int VW = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam int PW = 3 * COLORDEPTH;

  logic [HW-1:0]         h_cnt;
  logic [VW-1:0]         v_cnt;
  logic [2:0]            bar_idx;
  logic                  run;
  logic                  dec_dv;
  logic                  dec_hs;
  logic                  dec_vs;
  logic                  dec_frame;

  logic                  at_origin;
  pattern_e              pat_lat;
  pattern_e              pat_now;
  logic [PW-1:0]         solid_lat;
  logic [PW-1:0]         solid_now;
  logic [2:0]            bar_bits;
  logic [COLORDEPTH-1:0] ramp;
  logic [PW-1:0]         pix;

  logic [PW-1:0]         rgb;
  logic                  dv;
  logic                  hs;
  logic                  vs;
  logic                  frame;

  vid_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.en_i),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .bar_idx (bar_idx),
    .run     (run),
    .dv      (dec_dv),
    .hs      (dec_hs),
    .vs      (dec_vs),
    .frame   (dec_frame)
  );

  // At (0,0) the live inputs are used directly so the first pixel already
  // reflects the selection that gets latched for the rest of the frame.
  assign at_origin = run && (h_cnt == '0) && (v_cnt == '0);
  assign pat_now   = at_origin ? pattern_e'(bus.pattern_sel_i) : pat_lat;
  assign solid_now = at_origin ? bus.solid_rgb_i : solid_lat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_lat   <= PAT_BARS;
      solid_lat <= '0;
    end else if (at_origin) begin
      pat_lat   <= pattern_e'(bus.pattern_sel_i);
      solid_lat <= bus.solid_rgb_i;
    end
  end

  assign bar_bits = bar_rgb(bar_idx);
  assign ramp     = COLORDEPTH'(h_cnt);

  always_comb begin
    pix = '0;
    case (pat_now)
      PAT_BARS:  pix = {{COLORDEPTH{bar_bits[2]}}, {COLORDEPTH{bar_bits[1]}},
                        {COLORDEPTH{bar_bits[0]}}};
      PAT_RAMP:  pix = {3{ramp}};
      PAT_CHECK: pix = (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) ? '1 : '0;
      PAT_SOLID: pix = solid_now;
      default:   pix = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rgb   <= '0;
      dv    <= 1'b0;
      hs    <= 1'b0;
      vs    <= 1'b0;
      frame <= 1'b0;
    end else begin
      rgb   <= dec_dv ? pix : '0;
      dv    <= dec_dv;
      hs    <= dec_hs;
      vs    <= dec_vs;
      frame <= dec_frame;
    end
  end

  assign bus.red_o   = rgb[PW-1 -: COLORDEPTH];
  assign bus.green_o = rgb[2*COLORDEPTH-1 -: COLORDEPTH];
  assign bus.blue_o  = rgb[COLORDEPTH-1:0];
  assign bus.dv_o    = dv;
  assign bus.hs_o    = hs;
  assign bus.vs_o    = vs;
  assign bus.frame_o = frame;

endmodule
`default_nettype wire

// File: tb/tb_video_pattern_gen.sv
`default_nettype none
// ==== tb_video_pattern_gen : randomized self-checking bench for video_pattern_gen (rev 1.0) ====
module tb_video_pattern_gen;

  localparam int CD = 8;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4,  VF = 1, VS = 2, VB = 1;
  localparam int CL = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  video_pattern_gen_if #(.COLORDEPTH(CD)) vif ();

  video_pattern_gen #(
    .COLORDEPTH (CD),
    .H_ACTIVE   (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE   (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .CHECK_LOG2 (CL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  int          checks = 0;
  int          errors = 0;
  int          k;           // frame position of the pixel currently on the outputs
  logic [1:0]  cur_sel;
  logic [23:0] cur_solid;
  logic [1:0]  mdl_sel;
  logic [23:0] mdl_solid;
  logic [27:0] got;
  logic [27:0] want;

  function automatic logic [23:0] bar_colour(input int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Expected {rgb, dv, hs, vs, frame} for frame position pos.
  function automatic logic [27:0] expect_at(input int pos, input logic [1:0] sel,
                                            input logic [23:0] solid);
    int x, y;
    logic [23:0] c;
    logic d, h, v, f;
    x = pos % HT;
    y = (pos / HT) % VT;
    d = (x < HA) && (y < VA);
    h = (x >= HA + HF) && (x < HA + HF + HS);
    v = (y >= VA + VF) && (y < VA + VF + VS);
    f = (x == 0) && (y == 0);
    c = 24'h0;
    if (d) begin
      case (sel)
        2'd0:    c = bar_colour(x / (HA / 8));
        2'd1:    c = {3{8'(x)}};
        2'd2:    c = ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
        default: c = solid;
      endcase
    end
    return {c, d, h, v, f};
  endfunction

  function automatic logic [27:0] observed();
    return {vif.red_o, vif.green_o, vif.blue_o, vif.dv_o, vif.hs_o, vif.vs_o, vif.frame_o};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    vif.pattern_sel_i = cur_sel;
    vif.solid_rgb_i   = cur_solid;
  endtask

  task automatic next_pixel();
    step();
    k++;
    if (k % FT == 0) begin
      mdl_sel   = cur_sel;
      mdl_solid = cur_solid;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    vif.en_i  = 1'b1;
    cur_sel   = 2'd1;
    cur_solid = 24'h0;
    drive();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (observed() !== 28'h0) begin
        errors++;
        $display("FAIL reset_wins cycle=%0d got=%h want=0", i, observed());
      end
    end
  endtask

  task automatic test_timing();
    int n_frame, n_dv, n_hs, n_vs;
    n_frame = 0; n_dv = 0; n_hs = 0; n_vs = 0;
    rst = 1'b1;
    step();
    checks++;
    if (observed() !== 28'h0) begin
      errors++;
      $display("FAIL start_gap got=%h want=0", observed());
    end
    k = -1;
    for (int i = 0; i < 2 * FT; i++) begin
      next_pixel();
      got  = observed();
      want = expect_at(k, mdl_sel, mdl_solid);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL timing k=%0d got=%h want=%h", k, got, want);
      end
      n_frame += int'(vif.frame_o);
      n_dv    += int'(vif.dv_o);
      n_hs    += int'(vif.hs_o);
      n_vs    += int'(vif.vs_o);
    end
    checks++;
    if (n_frame != 2) begin errors++; $display("FAIL frame_count got=%0d want=2", n_frame); end
    checks++;
    if (n_dv != 2 * HA * VA) begin errors++; $display("FAIL dv_count got=%0d want=%0d", n_dv, 2 * HA * VA); end
    checks++;
    if (n_hs != 2 * VT * HS) begin errors++; $display("FAIL hs_count got=%0d want=%0d", n_hs, 2 * VT * HS); end
    checks++;
    if (n_vs != 2 * VS * HT) begin errors++; $display("FAIL vs_count got=%0d want=%0d", n_vs, 2 * VS * HT); end
  endtask

  task automatic test_patterns();
    for (int f = 0; f < 6; f++) begin
      cur_sel   = (f < 4) ? 2'(f) : 2'($urandom_range(0, 3));
      cur_solid = 24'($urandom);
      drive();
      for (int i = 0; i < FT; i++) begin
        next_pixel();
        got  = observed();
        want = expect_at(k, mdl_sel, mdl_solid);
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL pattern sel=%0d k=%0d got=%h want=%h", mdl_sel, k, got, want);
        end
        // Mid-frame input churn must not leak into the current frame.
        if ($urandom_range(0, 15) == 0) begin
          cur_sel   = 2'($urandom_range(0, 3));
          cur_solid = 24'($urandom);
          drive();
        end
      end
    end
  endtask

  task automatic test_latching();
    cur_sel = 2'd1;
    drive();
    for (int i = 0; i < 2 * FT; i++) begin
      next_pixel();
      got  = observed();
      want = expect_at(k, mdl_sel, mdl_solid);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL latch k=%0d got=%h want=%h", k, got, want);
      end
      if (i == FT) begin
        checks++;
        if ({vif.red_o, vif.green_o, vif.blue_o} !== 24'h123456) begin
          errors++;
          $display("FAIL latch_solid got=%h want=123456", {vif.red_o, vif.green_o, vif.blue_o});
        end
      end
      if (i == 30) begin
        cur_sel   = 2'd3;
        cur_solid = 24'h123456;
        drive();
      end
    end
  endtask

  task automatic test_enable();
    cur_sel = 2'd2;
    drive();
    for (int i = 0; i < FT; i++) begin
      next_pixel();
      got  = observed();
      want = expect_at(k, mdl_sel, mdl_solid);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL enable_drain k=%0d got=%h want=%h", k, got, want);
      end
      if (i == 2 * HT) vif.en_i = 1'b0;
      if (i == 60)     vif.en_i = 1'b1;
      if (i == 70)     vif.en_i = 1'b0;
    end
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (observed() !== 28'h0) begin
        errors++;
        $display("FAIL enable_idle cycle=%0d got=%h want=0", i, observed());
      end
    end
    cur_sel   = 2'd0;
    vif.en_i  = 1'b1;
    drive();
    step();
    checks++;
    if (observed() !== 28'h0) begin
      errors++;
      $display("FAIL enable_restart_gap got=%h want=0", observed());
    end
    k = -1;
    for (int i = 0; i < FT; i++) begin
      next_pixel();
      got  = observed();
      want = expect_at(k, mdl_sel, mdl_solid);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL enable_restart k=%0d got=%h want=%h", k, got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    cur_sel = 2'd1;
    drive();
    for (int i = 0; i < HT + 6; i++) begin
      next_pixel();
      got  = observed();
      want = expect_at(k, mdl_sel, mdl_solid);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL pre_reset k=%0d got=%h want=%h", k, got, want);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (observed() !== 28'h0) begin
        errors++;
        $display("FAIL mid_reset cycle=%0d got=%h want=0", i, observed());
      end
    end
    cur_sel   = 2'd3;
    cur_solid = 24'($urandom);
    drive();
    rst = 1'b1;
    step();
    checks++;
    if (observed() !== 28'h0) begin
      errors++;
      $display("FAIL post_reset_gap got=%h want=0", observed());
    end
    k = -1;
    for (int i = 0; i < FT; i++) begin
      next_pixel();
      got  = observed();
      want = expect_at(k, mdl_sel, mdl_solid);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL post_reset k=%0d got=%h want=%h", k, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_patterns();
    test_latching();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
